// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// ---------------------
// Arbitrates between two requesters (A = CPU writeback, B = debug/program
// loader) for the single register-file write port. Each cycle at most one
// requester is granted through a valid/ready handshake. The granted write is
// registered and presented to the register file one cycle later. Writes to
// register $0 are accepted but dropped, and counted. A starvation guard
// forces a grant to B after it has waited STARVE_LIMIT cycles in
// fixed-priority mode.
//
// Parameters
//   PRIORITY_MODE : 0 = round-robin, 1 = A fixed priority + B starvation guard
//   STARVE_LIMIT  : cycles B may wait before a forced grant (1..15)
//   CNT_W         : width of DropCount
//
// Ports
//   CLK        in   clock, rising edge
//   Reset      in   synchronous active-high reset
//   AValid     in   A has a write pending
//   AReady     out  A granted this cycle (combinational)
//   AAddr      in   A destination register [4:0]
//   AData      in   A write data [31:0]
//   BValid     in   B has a write pending
//   BReady     out  B granted this cycle (combinational)
//   BAddr      in   B destination register [4:0]
//   BData      in   B write data [31:0]
//   RegWre     out  registered write enable to the register file
//   WriteReg   out  registered write address [4:0]
//   WriteData  out  registered write data [31:0]
//   PendValid  out  write in flight this cycle (equals RegWre)
//   DropCount  out  saturating count of accepted writes to $0 [CNT_W-1:0]

module regfile_write_arbiter #(
    parameter int PRIORITY_MODE = 1,
    parameter int STARVE_LIMIT  = 4,
    parameter int CNT_W         = 8
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             AValid,
    output logic             AReady,
    input  logic [4:0]       AAddr,
    input  logic [31:0]      AData,
    input  logic             BValid,
    output logic             BReady,
    input  logic [4:0]       BAddr,
    input  logic [31:0]      BData,
    output logic             RegWre,
    output logic [4:0]       WriteReg,
    output logic [31:0]      WriteData,
    output logic             PendValid,
    output logic [CNT_W-1:0] DropCount
);

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_e;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    grant_e      last_grant;
    logic [3:0]  wait_cnt;
    logic        grant_a;
    logic        grant_b;
    logic        xfer;
    logic [4:0]  xfer_addr;
    logic [31:0] xfer_data;

    // Grant decision depends only on the valids and internal state, so the
    // ready outputs never combinationally depend on address or data.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!Reset) begin
            if (AValid && !BValid) begin
                grant_a = 1'b1;
            end else if (BValid && !AValid) begin
                grant_b = 1'b1;
            end else if (AValid && BValid) begin
                if (PRIORITY_MODE == 0) begin
                    if (last_grant == GRANT_B) grant_a = 1'b1;
                    else                       grant_b = 1'b1;
                end else begin
                    if (wait_cnt == LIMIT) grant_b = 1'b1;
                    else                   grant_a = 1'b1;
                end
            end
        end
    end

    assign AReady    = grant_a;
    assign BReady    = grant_b;
    assign xfer      = grant_a || grant_b;
    assign xfer_addr = grant_b ? BAddr : AAddr;
    assign xfer_data = grant_b ? BData : AData;
    assign PendValid = RegWre;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            last_grant <= GRANT_B;
            wait_cnt   <= '0;
            RegWre     <= 1'b0;
            WriteReg   <= '0;
            WriteData  <= '0;
            DropCount  <= '0;
        end else begin
            // Wait counter tracks only an uninterrupted wait by B.
            if (!BValid || grant_b) begin
                wait_cnt <= '0;
            end else if (wait_cnt < LIMIT) begin
                wait_cnt <= wait_cnt + 4'd1;
            end

            if (grant_a) begin
                last_grant <= GRANT_A;
            end else if (grant_b) begin
                last_grant <= GRANT_B;
            end

            RegWre <= xfer && (xfer_addr != 5'd0);
            if (xfer && (xfer_addr != 5'd0)) begin
                WriteReg  <= xfer_addr;
                WriteData <= xfer_data;
            end

            if (xfer && (xfer_addr == 5'd0) && (DropCount != '1)) begin
                DropCount <= DropCount + 1'b1;
            end
        end
    end

endmodule
